dds_gen_param: RTL and testbench

Parametrised, fully native-RTL direct digital synthesiser that replaces the vendor DDS core in the signal path of the function generator. It has a phase accumulator with runtime frequency load and step up/down, phase offset, phase sync, four selectable waveforms and amplitude scaling. It feeds the DAC and the LCD waveform-display path with a fixed-latency, valid-qualified sample stream.

---
 rtl/dds_gen_param.sv | 248 ++++++++++++++++++++++++
 tb/tb_dds_gen_param.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dds_gen_param.sv
`default_nettype none
//==============================================================================
// Module      : dds_gen_param
// Description : Parametrised direct digital synthesiser. A phase accumulator
//               driven by a runtime-adjustable tuning word (FTW) feeds a
//               3-stage pipeline that produces a sine, square, triangle or
//               sawtooth sample. The sample is scaled by an amplitude gain and
//               qualified by a valid strobe.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
// Ports:
//   clk_i               system clock
//   rst_n_i             synchronous active-low reset
//   en_i                advance accumulator / issue one sample this cycle
//   frequency_i         FTW value taken on freq_load_i
//   freq_load_i         load clamped frequency_i into the FTW
//   freq_step_i         step size for the up/down triggers
//   freq_up_trigger_i   FTW += step (saturating)
//   freq_down_trigger_i FTW -= step (saturating)
//   phase_offset_i      added to the accumulator before waveform lookup
//   phase_sync_i        clear the accumulator (wins over en_i)
//   wave_sel_i          0 sine, 1 square, 2 triangle, 3 sawtooth
//   amplitude_i         unsigned gain, unity = 2^AMP_W, larger values clamp
//   freq_word_o         current FTW
//   dds_phase_o         offset phase aligned with dds_wave_o
//   dds_wave_o          signed output sample
//   dds_wave_valid_o    dds_wave_o / dds_phase_o valid
//==============================================================================
module dds_gen_param #(
    parameter int                 PHASE_W  = 32,
    parameter int                 OUT_W    = 8,
    parameter int                 LUT_AW   = 10,
    parameter int                 AMP_W    = 8,
    parameter logic [PHASE_W-1:0] FREQ_MIN = '0,
    parameter logic [PHASE_W-1:0] FREQ_MAX = {1'b1, {(PHASE_W-1){1'b0}}}
) (
    input  logic                clk_i,
    input  logic                rst_n_i,
    input  logic                en_i,
    input  logic [PHASE_W-1:0]  frequency_i,
    input  logic                freq_load_i,
    input  logic [PHASE_W-1:0]  freq_step_i,
    input  logic                freq_up_trigger_i,
    input  logic                freq_down_trigger_i,
    input  logic [PHASE_W-1:0]  phase_offset_i,
    input  logic                phase_sync_i,
    input  logic [1:0]          wave_sel_i,
    input  logic [AMP_W:0]      amplitude_i,
    output logic [PHASE_W-1:0]  freq_word_o,
    output logic [PHASE_W-1:0]  dds_phase_o,
    output logic [OUT_W-1:0]    dds_wave_o,
    output logic                dds_wave_valid_o
);

    localparam int                      c_lut_n    = 1 << LUT_AW;
    localparam int                      c_maxv_i   = (1 << (OUT_W - 1)) - 1;
    localparam real                     c_pi       = 3.14159265358979323846;
    localparam logic signed [OUT_W-1:0] c_maxv     = {1'b0, {(OUT_W-1){1'b1}}};
    localparam logic signed [OUT_W-1:0] c_neg_maxv = -c_maxv;
    localparam logic [AMP_W:0]          c_unity    = {1'b1, {AMP_W{1'b0}}};

    localparam logic [1:0] c_sel_sine   = 2'd0;
    localparam logic [1:0] c_sel_square = 2'd1;
    localparam logic [1:0] c_sel_tri    = 2'd2;

    // One full-wave sine table entry, round-half-away-from-zero. Evaluated at
    // elaboration: the angle is folded into [0, pi/2] so a short Taylor series
    // is accurate far below one output LSB.
    function automatic logic signed [OUT_W-1:0] sine_entry(input int k);
        real x;
        real sgn;
        real term;
        real sum;
        real v;
        int  r;
        x   = 2.0 * c_pi * k / c_lut_n;
        sgn = 1.0;
        if (x > c_pi) begin
            x   = x - c_pi;
            sgn = -1.0;
        end
        if (x > c_pi / 2.0) begin
            x = c_pi - x;
        end
        term = x;
        sum  = x;
        for (int n = 1; n <= 12; n++) begin
            term = -term * x * x / ((2.0 * n) * (2.0 * n + 1.0));
            sum  = sum + term;
        end
        v = sgn * sum * c_maxv_i;
        if (v >= 0.0) begin
            r = $rtoi(v + 0.5);
        end else begin
            r = -$rtoi(0.5 - v);
        end
        sine_entry = r[OUT_W-1:0];
    endfunction

    // Saturate a PHASE_W+1 bit candidate into [FREQ_MIN, FREQ_MAX]. neg flags
    // a borrow out of the subtraction, i.e. a result below zero.
    function automatic logic [PHASE_W-1:0] clamp_ftw(input logic [PHASE_W:0] v,
                                                     input logic           neg);
        if (neg) begin
            clamp_ftw = FREQ_MIN;
        end else if (v > {1'b0, FREQ_MAX}) begin
            clamp_ftw = FREQ_MAX;
        end else if (v < {1'b0, FREQ_MIN}) begin
            clamp_ftw = FREQ_MIN;
        end else begin
            clamp_ftw = v[PHASE_W-1:0];
        end
    endfunction

    logic signed [OUT_W-1:0] w_rom [0:c_lut_n-1];

    for (genvar k = 0; k < c_lut_n; k++) begin : g_sine_rom
        assign w_rom[k] = sine_entry(k);
    end

    // Tuning word register
    logic [PHASE_W-1:0] r_ftw;
    logic [PHASE_W:0]   w_up_sum;
    logic [PHASE_W:0]   w_dn_diff;
    logic [PHASE_W-1:0] w_ftw_next;

    assign w_up_sum  = {1'b0, r_ftw} + {1'b0, freq_step_i};
    assign w_dn_diff = {1'b0, r_ftw} - {1'b0, freq_step_i};

    always_comb begin
        w_ftw_next = r_ftw;
        if (freq_load_i) begin
            w_ftw_next = clamp_ftw({1'b0, frequency_i}, 1'b0);
        end else if (freq_up_trigger_i && !freq_down_trigger_i) begin
            w_ftw_next = clamp_ftw(w_up_sum, 1'b0);
        end else if (freq_down_trigger_i && !freq_up_trigger_i) begin
            w_ftw_next = clamp_ftw(w_dn_diff, w_dn_diff[PHASE_W]);
        end
    end

    // Pipeline registers
    logic [PHASE_W-1:0]      r_acc;
    logic                    r_v0;
    logic [PHASE_W-1:0]      r_p1;
    logic [1:0]              r_sel1;
    logic [AMP_W:0]          r_amp1;
    logic                    r_v1;
    logic signed [OUT_W-1:0] r_w2;
    logic [PHASE_W-1:0]      r_p2;
    logic [AMP_W:0]          r_amp2;
    logic                    r_v2;
    logic [OUT_W-1:0]        r_y3;
    logic [PHASE_W-1:0]      r_p3;
    logic                    r_v3;

    // Stage 1 gain clamp
    logic [AMP_W:0] w_amp_clamped;
    assign w_amp_clamped = (amplitude_i > c_unity) ? c_unity : amplitude_i;

    // Stage 2 waveform generation from the offset phase
    logic                    w_m;
    logic [OUT_W-1:0]        w_top;
    logic [OUT_W-1:0]        w_t;
    logic [OUT_W-1:0]        w_tri_r;
    logic [LUT_AW-1:0]       w_lut_addr;
    logic signed [OUT_W-1:0] w_wave;

    assign w_m        = r_p1[PHASE_W-1];
    assign w_top      = r_p1[PHASE_W-1 -: OUT_W];
    assign w_t        = r_p1[PHASE_W-2 -: OUT_W];
    assign w_lut_addr = r_p1[PHASE_W-1 -: LUT_AW];
    // Fold the second half-cycle back down so t ramps up then down.
    assign w_tri_r    = w_m ? ~w_t : w_t;

    always_comb begin
        w_wave = {~w_top[OUT_W-1], w_top[OUT_W-2:0]};
        case (r_sel1)
            c_sel_sine:   w_wave = w_rom[w_lut_addr];
            c_sel_square: w_wave = w_m ? c_neg_maxv : c_maxv;
            c_sel_tri:    w_wave = {~w_tri_r[OUT_W-1], w_tri_r[OUT_W-2:0]};
            default:      w_wave = {~w_top[OUT_W-1], w_top[OUT_W-2:0]};
        endcase
    end

    // Stage 3 scaling: bit-slicing the signed product is a floor shift.
    logic signed [OUT_W+AMP_W+1:0] w_prod;
    logic                          w_unused_prod;

    assign w_prod        = r_w2 * $signed({1'b0, r_amp2});
    assign w_unused_prod = ^{w_prod[OUT_W+AMP_W+1 -: 2], w_prod[AMP_W-1:0]};

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_ftw  <= '0;
            r_acc  <= '0;
            r_v0   <= 1'b0;
            r_p1   <= '0;
            r_sel1 <= '0;
            r_amp1 <= '0;
            r_v1   <= 1'b0;
            r_w2   <= '0;
            r_p2   <= '0;
            r_amp2 <= '0;
            r_v2   <= 1'b0;
            r_y3   <= '0;
            r_p3   <= '0;
            r_v3   <= 1'b0;
        end else begin
            r_ftw <= w_ftw_next;

            if (phase_sync_i) begin
                r_acc <= '0;
            end else if (en_i) begin
                r_acc <= r_acc + r_ftw;
            end
            r_v0 <= en_i & ~phase_sync_i;

            // Each stage only loads when a sample arrives, so the outputs
            // hold their last value across gaps in en_i.
            r_v1 <= r_v0;
            if (r_v0) begin
                r_p1   <= r_acc + phase_offset_i;
                r_sel1 <= wave_sel_i;
                r_amp1 <= w_amp_clamped;
            end

            r_v2 <= r_v1;
            if (r_v1) begin
                r_w2   <= w_wave;
                r_p2   <= r_p1;
                r_amp2 <= r_amp1;
            end

            r_v3 <= r_v2;
            if (r_v2) begin
                r_y3 <= w_prod[AMP_W +: OUT_W];
                r_p3 <= r_p2;
            end
        end
    end

    assign freq_word_o      = r_ftw;
    assign dds_phase_o      = r_p3;
    assign dds_wave_o       = r_y3;
    assign dds_wave_valid_o = r_v3;

endmodule
`default_nettype wire

// File: tb/tb_dds_gen_param.sv
`default_nettype none
//==============================================================================
// Module      : tb_dds_gen_param
// Description : Self-checking bench for dds_gen_param (default parameters).
//               A cycle model of the synthesiser rules is compared against the
//               DUT every clock; directed sequences pin literal samples.
// Revision    : 1.0 - initial release
//==============================================================================
module tb_dds_gen_param;

    localparam longint c_mod  = 64'h1_0000_0000;
    localparam longint c_fmax = 64'h8000_0000;
    localparam longint c_q    = 64'h4000_0000;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        en          = 1'b0;
    logic [31:0] frequency   = '0;
    logic        freq_load   = 1'b0;
    logic [31:0] step        = '0;
    logic        up          = 1'b0;
    logic        down        = 1'b0;
    logic [31:0] offset      = '0;
    logic        sync        = 1'b0;
    logic [1:0]  sel         = '0;
    logic [8:0]  amp         = '0;
    logic [31:0] fw;
    logic [31:0] ph;
    logic [7:0]  wv;
    logic        vld;

    int total = 0;
    int bad   = 0;

    int     cw [8];
    longint cp [8];

    dds_gen_param dut (
        .clk_i               (clk),
        .rst_n_i             (rst_n),
        .en_i                (en),
        .frequency_i         (frequency),
        .freq_load_i         (freq_load),
        .freq_step_i         (step),
        .freq_up_trigger_i   (up),
        .freq_down_trigger_i (down),
        .phase_offset_i      (offset),
        .phase_sync_i        (sync),
        .wave_sel_i          (sel),
        .amplitude_i         (amp),
        .freq_word_o         (fw),
        .dds_phase_o         (ph),
        .dds_wave_o          (wv),
        .dds_wave_valid_o    (vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint clampf(input longint v);
        if (v < 0)      return 0;
        if (v > c_fmax) return c_fmax;
        return v;
    endfunction

    function automatic int ref_wave(input longint p, input int s, input int a);
        int     w;
        int     ac;
        longint t;
        real    x;
        real    r;
        ac = (a > 256) ? 256 : a;
        case (s)
            0: begin
                x = 2.0 * 3.14159265358979323846 * real'(p >> 22) / 1024.0;
                r = 127.0 * $sin(x);
                w = (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
            end
            1: w = (p < c_fmax) ? 127 : -127;
            2: begin
                t = (p >> 23) % 256;
                w = (p >= c_fmax) ? int'(255 - t) - 128 : int'(t) - 128;
            end
            default: w = int'(p >> 24) - 128;
        endcase
        return (w * ac) >>> 8;
    endfunction

    longint m_ftw = 0;
    longint m_acc = 0;
    bit     m_av  = 0;
    bit     d1_v  = 0;
    bit     d2_v  = 0;
    bit     o_v   = 0;
    longint d1_p  = 0;
    longint d2_p  = 0;
    longint o_p   = 0;
    int     d1_w  = 0;
    int     d2_w  = 0;
    int     o_w   = 0;

    always @(posedge clk) begin
        longint st;
        longint of;
        longint fq;
        st = {32'd0, step};
        of = {32'd0, offset};
        fq = {32'd0, frequency};
        if (!rst_n) begin
            m_ftw = 0; m_acc = 0; m_av = 0;
            d1_v = 0; d2_v = 0; o_v = 0;
            d1_p = 0; d2_p = 0; o_p = 0;
            d1_w = 0; d2_w = 0; o_w = 0;
        end else begin
            if (d2_v) begin
                o_w = d2_w;
                o_p = d2_p;
            end
            o_v  = d2_v;
            d2_v = d1_v; d2_w = d1_w; d2_p = d1_p;
            d1_v = m_av;
            if (m_av) begin
                d1_p = (m_acc + of) % c_mod;
                d1_w = ref_wave(d1_p, int'(sel), int'(amp));
            end
            m_av = en && !sync;
            if (sync)    m_acc = 0;
            else if (en) m_acc = (m_acc + m_ftw) % c_mod;
            if (freq_load)         m_ftw = clampf(fq);
            else if (up && !down)  m_ftw = clampf(m_ftw + st);
            else if (down && !up)  m_ftw = clampf(m_ftw - st);
        end
    end

    always @(posedge clk) begin
        #1;
        check("cyc_freq_word", {32'd0, fw}, m_ftw);
        check("cyc_valid", longint'(vld), longint'(o_v));
        check("cyc_wave", longint'($signed(wv)), longint'(o_w));
        check("cyc_phase", {32'd0, ph}, o_p);
    end

    // ---------------- directed stimulus ----------------
    task automatic collect(input int n);
        int got;
        int waited;
        got    = 0;
        waited = 0;
        while (got < n && waited < 100) begin
            @(negedge clk);
            waited++;
            if (vld) begin
                cw[got] = int'($signed(wv));
                cp[got] = {32'd0, ph};
                got++;
            end
        end
        if (got < n) begin
            total++;
            bad++;
            $display("FAIL collect_timeout got=%0d required=%0d", got, n);
        end
    endtask

    task automatic run_wave(input string nm, input int s, input int a, input longint off,
                            input int w0, input int w1, input int w2, input int w3,
                            input longint p0);
        int ew [4];
        @(negedge clk);
        en = 1'b0; sync = 1'b1;
        sel = 2'(s); amp = 9'(a); offset = 32'(off);
        repeat (4) @(negedge clk);
        sync = 1'b0; en = 1'b1;
        collect(4);
        ew = '{w0, w1, w2, w3};
        for (int i = 0; i < 4; i++) begin
            check({nm, "_wave"}, longint'(cw[i]), longint'(ew[i]));
            check({nm, "_phase"}, cp[i], (p0 + i * c_q) % c_mod);
        end
    endtask

    initial begin
        int sv [6];
        int sexp [6];
        int sw;

        // Reset with random inputs
        en = 1'($urandom); freq_load = 1'($urandom); up = 1'($urandom);
        down = 1'($urandom); sync = 1'($urandom); sel = 2'($urandom);
        amp = 9'($urandom); frequency = $urandom; step = $urandom; offset = $urandom;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        en = 0; freq_load = 0; up = 0; down = 0; sync = 0;
        frequency = 0; step = 0; offset = 0; sel = 0; amp = 0;
        @(negedge clk);
        check("rst_freq_word", {32'd0, fw}, 0);
        check("rst_valid", longint'(vld), 0);
        check("rst_wave", longint'($signed(wv)), 0);
        check("rst_phase", {32'd0, ph}, 0);

        // Load quarter-rate tuning word
        frequency = 32'h4000_0000; freq_load = 1'b1;
        @(negedge clk);
        freq_load = 1'b0;
        check("ftw_load", {32'd0, fw}, c_q);

        // Sine, latency of the first sample
        sync = 1'b1; sel = 2'd0; amp = 9'd256; offset = 0;
        @(negedge clk);
        sync = 1'b0; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("latency_no_valid", longint'(vld), 0);
        end
        @(negedge clk);
        check("first_valid", longint'(vld), 1);
        check("first_sine", longint'($signed(wv)), 127);
        check("first_phase", {32'd0, ph}, c_q);
        collect(3);
        check("sine_1", longint'(cw[0]), 0);
        check("sine_2", longint'(cw[1]), -127);
        check("sine_3", longint'(cw[2]), 0);
        check("sine_ph3", cp[2], 0);

        run_wave("saw",     3, 256, 0,      -64,   0,   64, -128, c_q);
        run_wave("tri",     2, 256, 0,        0, 127,   -1, -128, c_q);
        run_wave("square",  1, 256, 0,      127, -127, -127, 127, c_q);
        run_wave("amp128",  0, 128, 0,       63,   0,  -64,    0, c_q);
        run_wave("amp0",    0,   0, 0,        0,   0,    0,    0, c_q);
        run_wave("offset",  0, 256, c_fmax, -127,  0,  127,    0, 3 * c_q);
        run_wave("amp511",  0, 511, 0,      127,   0, -127,    0, c_q);

        // Phase sync pulse mid-stream: exactly one missing sample
        @(negedge clk);
        sync = 1'b1;
        @(negedge clk);
        sync = 1'b0;
        sv[0] = int'(vld);
        sw = 0;
        for (int i = 1; i < 6; i++) begin
            @(negedge clk);
            sv[i] = int'(vld);
            if (i == 4) sw = int'($signed(wv));
        end
        sexp = '{1, 1, 1, 0, 1, 1};
        for (int i = 0; i < 6; i++) begin
            check("sync_gap_valid", longint'(sv[i]), longint'(sexp[i]));
        end
        check("sync_restart_wave", longint'(sw), 127);

        // Frequency load / step / clamp while streaming
        @(negedge clk);
        frequency = 32'h7FFF_FFFD; freq_load = 1'b1;
        @(negedge clk);
        freq_load = 1'b0;
        check("ftw_near_max", {32'd0, fw}, c_fmax - 3);
        step = 32'd5; up = 1'b1;
        @(negedge clk);
        up = 1'b0;
        check("ftw_up_sat", {32'd0, fw}, c_fmax);
        frequency = 32'd3; freq_load = 1'b1;
        @(negedge clk);
        freq_load = 1'b0; down = 1'b1;
        @(negedge clk);
        down = 1'b0;
        check("ftw_down_sat", {32'd0, fw}, 0);
        frequency = 32'd1000; freq_load = 1'b1;
        @(negedge clk);
        freq_load = 1'b0; up = 1'b1; down = 1'b1;
        @(negedge clk);
        up = 1'b0; down = 1'b0;
        check("ftw_both_hold", {32'd0, fw}, 1000);
        frequency = 32'd777; freq_load = 1'b1; up = 1'b1;
        @(negedge clk);
        freq_load = 1'b0; up = 1'b0;
        check("ftw_load_wins", {32'd0, fw}, 777);
        frequency = 32'hFFFF_FFFF; freq_load = 1'b1;
        @(negedge clk);
        freq_load = 1'b0;
        check("ftw_load_clamp", {32'd0, fw}, c_fmax);
        frequency = 32'd0; freq_load = 1'b1;
        @(negedge clk);
        freq_load = 1'b0;
        repeat (5) @(negedge clk);
        check("ftw_zero_valid", longint'(vld), 1);

        // Reset mid-stream
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", longint'(vld), 0);
        check("midrst_wave", longint'($signed(wv)), 0);
        check("midrst_freq_word", {32'd0, fw}, 0);
        rst_n = 1'b1; en = 1'b0;
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog_timeout reached=1 required=0");
        $fatal(1);
    end

endmodule
`default_nettype wire
